// File: rtl/uart_rx_if.sv
// Serial receive bundle for uart_rx.
//   rx        : serial line into the receiver (idle high)
//   rx_data   : last correctly framed byte
//   rx_valid  : one-cycle strobe, rx_data updated
//   frame_err : one-cycle strobe, stop bit sampled low
//   idle      : receiver has no frame in progress
// master = line driver / byte consumer, slave = the receiver.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       idle;

    modport master (output rx, input rx_data, rx_valid, frame_err, idle);
    modport slave  (input rx, output rx_data, rx_valid, frame_err, idle);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Oversamples rx with clk, validates the start bit at its
// centre, samples 8 data bits LSB-first at bit centres and checks the stop bit.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_rx_if.slave (rx in; rx_data, rx_valid, frame_err, idle out)
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_rx_if.slave   bus
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state;
    logic          rx_meta, rx_s;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q, frame_err_q, idle_q;

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.idle      = idle_q;

    // Two-flop synchronizer; resets to the idle line level so reset release
    // never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    // idle_q is registered alongside every state change so it always matches
    // (state == IDLE) without a combinational output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_s) begin
                        state  <= START;
                        idle_q <= 1'b0;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            // line went high before mid start bit: glitch
                            state  <= IDLE;
                            idle_q <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        if (bit_cnt == 3'd7) state <= STOP;
                        else                 bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            // return to IDLE mid stop bit so a start bit with
                            // zero idle gap is still caught
                            rx_data_q  <= shreg;
                            rx_valid_q <= 1'b1;
                            state      <= IDLE;
                            idle_q     <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= WAIT_HIGH;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // a break holds the line low; report it once, then wait
                    if (rx_s) begin
                        state  <= IDLE;
                        idle_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    idle_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx (CLKS_PER_BIT=16). A frame driver acts as the
// transmitter; each frame pushes its expected outcome into a scoreboard queue
// and an independent monitor pops and compares on every output strobe.
module tb_uart_rx;
    localparam int C = 16;
    localparam int H = C / 2;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         exp_cyc;   // -1: latency not checked
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] last_good = 8'h00;
    exp_t sb[$];
    exp_t mon_e;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame starting at a negedge. p2 = bit period in half
    // clocks; bit boundaries are rounded down from i*p2/2 so fractional
    // periods average out exactly.
    task automatic send(input logic [7:0] b, input bit stop, input int p2, input bit timed);
        exp_t e;
        logic [9:0] frame;
        frame     = {stop, b, 1'b0};
        e.is_err  = !stop;
        e.data    = stop ? b : last_good;
        // rx is first sampled on the next posedge; strobe is H + 9C + 2 later
        e.exp_cyc = timed ? (cyc + 1 + H + 9*C + 2) : -1;
        if (stop) last_good = b;
        sb.push_back(e);
        for (int i = 0; i < 10; i++) begin
            bus.rx = frame[i];
            wait_neg(((i + 1) * p2) / 2 - (i * p2) / 2);
        end
    endtask

    task automatic gap(input int bits);
        bus.rx = 1'b1;
        wait_neg(bits * C);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, sb.size(), 0);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.rx_valid && bus.frame_err) begin
                checks++;
                errors++;
                $display("FAIL both_strobes: rx_valid and frame_err together at cyc %0d", cyc);
            end
            if (bus.rx_valid || bus.frame_err) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: valid=%0b ferr=%0b data=%0h, none expected",
                             bus.rx_valid, bus.frame_err, bus.rx_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk("strobe_kind(ferr)", int'(bus.frame_err), int'(mon_e.is_err));
                    chk("rx_data", int'(bus.rx_data), int'(mon_e.data));
                    if (mon_e.exp_cyc >= 0) chk("latency_cyc", cyc, mon_e.exp_cyc);
                end
            end
        end
    end

    initial begin
        int n;
        logic [7:0] c3;
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        wait_neg(5);
        chk("reset_rx_data", int'(bus.rx_data), 0);
        chk("reset_rx_valid", int'(bus.rx_valid), 0);
        chk("reset_frame_err", int'(bus.frame_err), 0);
        chk("reset_idle", int'(bus.idle), 1);
        rst_n = 1'b1;
        wait_neg(5);

        // Loopback bytes
        send(8'hAA, 1'b1, 2*C, 1'b0); gap(1);
        send(8'h55, 1'b1, 2*C, 1'b0); gap(1);
        send(8'h00, 1'b1, 2*C, 1'b0); gap(1);
        send(8'hFF, 1'b1, 2*C, 1'b0); gap(1);
        drain("loopback_drain");

        // Glitch shorter than half a bit
        bus.rx = 1'b0;
        wait_neg(5);
        chk("glitch_not_idle", int'(bus.idle), 0);
        bus.rx = 1'b1;
        n = 0;
        while (bus.idle !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("glitch_idle_back", int'(bus.idle), 1);
        gap(1);
        send(8'h3C, 1'b1, 2*C, 1'b0); gap(1);

        // Framing error followed by a long break
        send(8'hA5, 1'b0, 2*C, 1'b0);
        wait_neg(40 * C);
        chk("break_not_idle", int'(bus.idle), 0);
        gap(2);
        send(8'h5A, 1'b1, 2*C, 1'b0); gap(1);
        drain("ferr_drain");

        // Back-to-back, zero idle gap, latency checked
        send(8'h01, 1'b1, 2*C, 1'b1);
        send(8'h80, 1'b1, 2*C, 1'b1);
        send(8'h7E, 1'b1, 2*C, 1'b1);
        gap(1);
        drain("b2b_drain");

        // Reset during bit 4 of 0xC3
        c3 = 8'hC3;
        bus.rx = 1'b0;
        wait_neg(C);
        for (int i = 0; i < 4; i++) begin
            bus.rx = c3[i];
            wait_neg(C);
        end
        bus.rx = c3[4];
        wait_neg(H);
        rst_n  = 1'b0;
        #1;
        chk("midrst_rx_data", int'(bus.rx_data), 0);
        chk("midrst_idle", int'(bus.idle), 1);
        chk("midrst_rx_valid", int'(bus.rx_valid), 0);
        last_good = 8'h00;
        bus.rx = 1'b1;
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(20);
        chk("postrst_rx_data", int'(bus.rx_data), 0);
        send(8'h96, 1'b1, 2*C, 1'b0); gap(1);
        drain("midrst_drain");

        // Baud skew
        send(8'hAA, 1'b1, 2*C - 1, 1'b0); gap(1);
        send(8'h55, 1'b1, 2*C + 1, 1'b0); gap(1);
        drain("skew_drain");

        // Random frames: data, period within tolerance, occasional bad stop
        for (int k = 0; k < 30; k++) begin
            logic [7:0] b;
            int  p2;
            bit  stop;
            b    = 8'($urandom);
            p2   = int'($urandom_range(2*C - 1, 2*C + 1));
            stop = ($urandom_range(0, 7) != 0);
            send(b, stop, p2, 1'b0);
            if (!stop) begin
                wait_neg(int'($urandom_range(0, 3)) * C);
                gap(int'($urandom_range(1, 2)));
            end else begin
                gap(int'($urandom_range(0, 2)));
            end
        end
        gap(1);
        drain("random_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
